// File: rtl/mux_scan_sequencer_if.sv
// Handshake and bus bundle between the scan sequencer and its mux/consumer side.
// The slave modport is the sequencer; the master modport drives start/ack/cont and the mux output.
interface mux_scan_sequencer_if;
  logic       start;
  logic       cont;
  logic       y_in;
  logic       ack;
  logic       s0;
  logic       s1;
  logic       s2;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;

  modport master (
    output start, cont, y_in, ack,
    input  s0, s1, s2, data_out, valid, busy
  );

  modport slave (
    input  start, cont, y_in, ack,
    output s0, s1, s2, data_out, valid, busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Walks an external 8:1 mux through channels 0..7, one sample per cycle, and presents the word.
// 8 SCAN cycles from start to valid; the word is held (valid=1) until ack, with optional back-to-back rescans.
module mux_scan_sequencer (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] cap, cap_nxt;
  logic [7:0] data_q, data_nxt;
  logic       valid_q, valid_nxt;
  logic [2:0] sel_q;
  logic       busy_q;

  // Selects and busy are registered from next-state values so they line up with state yet never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      cap     <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cap     <= cap_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      sel_q   <= (state_nxt == SCAN) ? cnt_nxt : 3'd0;
      busy_q  <= (state_nxt == SCAN);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SCAN;
      SCAN:    if (cnt == 3'd7) state_nxt = HOLD;
      HOLD:    if (bus.ack) state_nxt = bus.cont ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt   = cnt;
    cap_nxt   = cap;
    data_nxt  = data_q;
    valid_nxt = valid_q;
    case (state)
      IDLE: if (bus.start) cnt_nxt = 3'd0;
      SCAN: begin
        cap_nxt[cnt] = bus.y_in;
        if (cnt == 3'd7) begin
          // Last channel goes straight into the word rather than through the capture register.
          data_nxt  = {bus.y_in, cap[6:0]};
          valid_nxt = 1'b1;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      HOLD: if (bus.ack) begin
        valid_nxt = 1'b0;
        cnt_nxt   = 3'd0;
      end
      default: cnt_nxt = 3'd0;
    endcase
  end

  assign bus.s0       = sel_q[0];
  assign bus.s1       = sel_q[1];
  assign bus.s2       = sel_q[2];
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: mux model on the bus, expected words in a scoreboard queue.
module tb_mux_scan_sequencer;

  logic clk;
  logic rst_n;
  logic [7:0] chan;
  logic use_tog;
  logic tog;

  int checks;
  int errors;
  int words_seen;
  logic [7:0] exp_q[$];
  logic valid_d;

  mux_scan_sequencer_if ifc ();

  mux_scan_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8:1 mux, or a free-running toggle source for the time-varying case.
  assign ifc.y_in = use_tog ? tog : chan[{ifc.s2, ifc.s1, ifc.s0}];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (ifc.valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ifc.valid, 1);
  endtask

  // Scoreboard: every rising edge of valid must match the oldest expected word.
  initial valid_d = 1'b0;
  always @(negedge clk) begin
    if (ifc.valid === 1'b1 && valid_d !== 1'b1) begin
      words_seen++;
      chk("word_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("data_out", ifc.data_out, exp_q.pop_front());
    end
    valid_d = ifc.valid;
  end

  initial begin
    int w0;
    checks = 0; errors = 0; words_seen = 0;
    rst_n = 1'b0; chan = 8'hA6; use_tog = 1'b0; tog = 1'b0;
    ifc.start = 1'b0; ifc.cont = 1'b0; ifc.ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", ifc.valid, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_sel", {ifc.s2, ifc.s1, ifc.s0}, 0);
    chk("rst_data", ifc.data_out, 8'h00);

    // Single scan with channels A6
    ifc.start = 1'b1; exp_q.push_back(8'hA6);
    @(negedge clk);
    ifc.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("scan_busy", ifc.busy, 1);
      chk("scan_sel", {ifc.s2, ifc.s1, ifc.s0}, k);
      chk("scan_novalid", ifc.valid, 0);
      @(negedge clk);
    end
    chk("done_valid", ifc.valid, 1);

    // Back-pressure: hold for 20 cycles
    for (int k = 0; k < 20; k++) begin
      chk("hold_valid", ifc.valid, 1);
      chk("hold_data", ifc.data_out, 8'hA6);
      chk("hold_sel", {ifc.s2, ifc.s1, ifc.s0}, 0);
      chk("hold_busy", ifc.busy, 0);
      @(negedge clk);
    end
    ifc.ack = 1'b1;
    @(negedge clk);
    ifc.ack = 1'b0;
    chk("ack_valid", ifc.valid, 0);
    chk("ack_busy", ifc.busy, 0);
    chk("keep_data", ifc.data_out, 8'hA6);
    repeat (2) @(negedge clk);
    chk("idle_busy", ifc.busy, 0);

    // Continuous mode: second scan starts right after ack
    ifc.cont = 1'b1; ifc.start = 1'b1; exp_q.push_back(8'hA6);
    @(negedge clk);
    ifc.start = 1'b0;
    wait_valid("cont_wait1");
    chan = 8'h3C; exp_q.push_back(8'h3C); ifc.ack = 1'b1;
    @(negedge clk);
    ifc.ack = 1'b0; ifc.cont = 1'b0;
    chk("cont_rescan_busy", ifc.busy, 1);
    chk("cont_rescan_sel", {ifc.s2, ifc.s1, ifc.s0}, 0);
    chk("cont_rescan_valid", ifc.valid, 0);
    chk("cont_keep_data", ifc.data_out, 8'hA6);
    wait_valid("cont_wait2");
    chk("cont_word2", ifc.data_out, 8'h3C);
    ifc.ack = 1'b1;
    @(negedge clk);
    ifc.ack = 1'b0;
    chk("cont_end_valid", ifc.valid, 0);
    chk("cont_end_busy", ifc.busy, 0);

    // Reset mid-scan at cnt=4
    chan = 8'hA6; w0 = words_seen;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_sel4", {ifc.s2, ifc.s1, ifc.s0}, 4);
    rst_n = 1'b0; ifc.ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; ifc.ack = 1'b0;
    chk("mrst_sel", {ifc.s2, ifc.s1, ifc.s0}, 0);
    chk("mrst_valid", ifc.valid, 0);
    chk("mrst_busy", ifc.busy, 0);
    chk("mrst_data", ifc.data_out, 8'h00);
    repeat (15) @(negedge clk);
    chk("mrst_no_word", words_seen - w0, 0);
    chk("mrst_idle_busy", ifc.busy, 0);

    // Ignored inputs: start in SCAN/HOLD, ack in IDLE
    w0 = words_seen;
    ifc.start = 1'b1; exp_q.push_back(8'hA6);
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_valid("ign_wait");
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("ign_hold_valid", ifc.valid, 1);
    chk("ign_hold_busy", ifc.busy, 0);
    ifc.start = 1'b1; ifc.ack = 1'b1; ifc.cont = 1'b0;
    @(negedge clk);
    ifc.start = 1'b0; ifc.ack = 1'b0;
    chk("ign_startack_busy", ifc.busy, 0);
    chk("ign_startack_valid", ifc.valid, 0);
    ifc.ack = 1'b1;
    @(negedge clk);
    ifc.ack = 1'b0;
    repeat (12) @(negedge clk);
    chk("ign_one_word", words_seen - w0, 1);
    chk("ign_idle_busy", ifc.busy, 0);
    ifc.start = 1'b1; exp_q.push_back(8'hA6);
    @(negedge clk);
    ifc.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("ign_scan_sel", {ifc.s2, ifc.s1, ifc.s0}, k);
      @(negedge clk);
    end
    chk("ign_scan_valid", ifc.valid, 1);
    @(negedge clk);
    chk("ack_not_stored", ifc.valid, 1);
    ifc.ack = 1'b1;
    @(negedge clk);
    ifc.ack = 1'b0;

    // Time-varying y_in: 1,0,1,0... from select 0
    use_tog = 1'b1; tog = 1'b1; ifc.start = 1'b1; exp_q.push_back(8'h55);
    @(negedge clk);
    ifc.start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      tog = ~tog;
    end
    wait_valid("tog_wait");
    chk("tog_word", ifc.data_out, 8'h55);
    ifc.ack = 1'b1;
    @(negedge clk);
    ifc.ack = 1'b0;
    @(negedge clk);

    chk("sb_drained", exp_q.size(), 0);
    chk("total_words", words_seen, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, with all state changing only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request one scan of all 8 channels; sampled only in IDLE.
REQ-005 cont  input  1  continuous mode; sampled on the edge where ack is accepted.
REQ-006 y_in  input  1  output of the downstream 8:1 channel mux, fed back combinationally.
REQ-007 s0, s1, s2  output  1 each  channel select to the 8:1 mux (s2 is the MSB), registered.
REQ-008 ack  input  1  consumer accepts data_out; meaningful only while valid=1.
REQ-009 data_out  output  8  captured word; bit k holds y_in sampled while select = k.
REQ-010 valid  output  1  data_out holds a complete word.
REQ-011 busy  output  1  high in SCAN.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SCAN, HOLD.
REQ-013 In IDLE with start=1, the next state SHALL be SCAN with the channel counter at 0.
REQ-014 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-015 In SCAN, {s2,s1,s0} SHALL equal the 3-bit channel counter cnt.
REQ-016 In SCAN, on each edge y_in SHALL be stored into capture bit cnt and cnt SHALL increment by 1.
REQ-017 In SCAN with cnt=7, the next edge SHALL load data_out with {y_in, capture[6:0]}, set valid=1, enter HOLD, and reset cnt to 0, without wrapping into a 9th sample.
REQ-018 A scan SHALL take exactly 8 SCAN cycles: if start is sampled at edge E0, y_in is sampled at edges E1..E8 and valid=1 is visible after E8.
REQ-019 In IDLE and HOLD, {s2,s1,s0} SHALL be 3'b000 and busy SHALL be 0.
REQ-020 In HOLD, data_out and valid SHALL remain stable until ack=1 is sampled.
REQ-021 In HOLD with ack=1 and cont=1, the FSM SHALL go to SCAN with valid cleared, starting a new scan with no idle cycle.
REQ-022 In HOLD with ack=1 and cont=0, the FSM SHALL go to IDLE with valid cleared.
REQ-023 data_out SHALL keep its last value after valid clears and SHALL change only when the next scan completes.
REQ-024 start asserted in SCAN or HOLD SHALL be ignored, including start and ack together in HOLD, where cont alone decides the next state.
REQ-025 ack asserted while valid=0 SHALL be ignored and SHALL NOT be stored.
REQ-026 cont SHALL be ignored everywhere except on the HOLD-ack edge.
REQ-027 Select outputs SHALL be glitch-free, driven from registers only.

Reset
REQ-028 When rst_n=0 is sampled, the next state SHALL be IDLE.
REQ-029 The same reset edge SHALL set cnt, the capture register and data_out to 0, valid and busy to 0, and {s2,s1,s0} to 000.
REQ-030 Reset SHALL take priority over start and ack.
REQ-031 Reset mid-scan or in HOLD SHALL discard the partial or held word, with no valid pulse produced.
REQ-032 After rst_n returns to 1, the block SHALL need a fresh start to begin a scan.

Verification
REQ-033 Single scan: bench models the mux with channels i7..i0 = 8'b1010_0110 and pulses start for 1 cycle -> busy=1 for 8 cycles, selects 0,1,...,7 on consecutive cycles, then valid=1 with data_out=8'hA6 after edge E8, held until ack.
REQ-034 Back-pressure: ack held low for 20 cycles after valid -> data_out stays 8'hA6, valid stays 1, selects stay 000, busy stays 0 throughout.
REQ-035 Continuous mode: cont=1, ack pulsed as soon as valid is seen, channels changed to 8'h3C before the second scan -> SCAN is re-entered on the cycle after ack and the second word is 8'h3C with no idle cycle between scans.
REQ-036 Reset mid-scan: rst_n=0 for 1 cycle while cnt=4 -> next cycle state is IDLE with selects 000, valid=0, data_out=8'h00, and no valid is produced until a new start.
REQ-037 Ignored inputs: start pulsed during SCAN and during HOLD, and ack pulsed while IDLE -> exactly one word is produced, and a later start in IDLE gives a normal 8-cycle scan.
REQ-038 Time-varying input: y_in toggles every cycle, starting at 1 on the cycle with select=0 -> data_out=8'h55.
